rf_op_sequencer: RTL and testbench

// - Multi-cycle command sequencer in front of RegisterFile (R1-R4, S1-S4).
// - Accepts one register-level command per valid/ready handshake and drives I, OutASel, OutBSel,

---
 rtl/rf_op_sequencer_pkg.sv | 42 ++++
 rtl/rf_addr_decoder.sv | 18 +
 rtl/rf_op_sequencer.sv | 133 +++++++++++++
 tb/tb_rf_op_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_op_sequencer_pkg.sv
// Shared definitions for the RegisterFile command sequencer: op codes, RF function
// codes, FSM states and the R1..S4 address map helpers.
package rf_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_MOVE  = 3'd5,
    OP_SWAP  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    FUN_DEC   = 3'd0,
    FUN_INC   = 3'd1,
    FUN_LOAD  = 3'd2,
    FUN_CLEAR = 3'd3
  } fun_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWAP2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Address map: 0..3 = R1..R4, 4..7 = S1..S4
  localparam logic [2:0] ADDR_R1 = 3'd0;
  localparam logic [2:0] ADDR_S1 = 3'd4;

  function automatic logic isScratch(input logic [2:0] addr);
    return addr >= ADDR_S1;
  endfunction

  function automatic logic [1:0] addrOffset(input logic [2:0] addr);
    return 2'(addr - (isScratch(addr) ? ADDR_S1 : ADDR_R1));
  endfunction

endpackage

// File: rtl/rf_addr_decoder.sv
// Turns a 3-bit RF address plus write enable into one-hot RegSel/ScrSel
// (bit3 selects R1/S1, bit0 selects R4/S4).
module rf_addr_decoder
  import rf_op_sequencer_pkg::*;
(
  input  logic [2:0] addr,
  input  logic       en,
  output logic [3:0] regSel,
  output logic [3:0] scrSel
);

  logic [3:0] oneHot;

  assign oneHot = 4'b1000 >> addrOffset(addr);
  assign regSel = (en && !isScratch(addr)) ? oneHot : 4'b0000;
  assign scrSel = (en &&  isScratch(addr)) ? oneHot : 4'b0000;

endmodule

// File: rtl/rf_op_sequencer.sv
// Multi-cycle command sequencer in front of RegisterFile: accepts one register-level
// command per handshake and drives I/OutASel/OutBSel/FunSel/RegSel/ScrSel over 1..N cycles.
module rf_op_sequencer
  import rf_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] rf_out_a,
  input  logic [DATA_W-1:0] rf_out_b,
  output logic [DATA_W-1:0] I,
  output logic [2:0]        OutASel,
  output logic [2:0]        OutBSel,
  output logic [2:0]        FunSel,
  output logic [3:0]        RegSel,
  output logic [3:0]        ScrSel,
  output logic              busy,
  output logic              done
);

  state_e            state, nextState;
  op_e               cmdOp;
  logic [2:0]        cmdDst, cmdSrc;
  logic [DATA_W-1:0] cmdImm, hold;
  logic [CNT_W-1:0]  cnt;
  logic              accept, isIncDec;
  logic              wrEn;
  logic [2:0]        wrAddr;

  assign accept   = cmd_valid && (state == ST_IDLE);
  assign isIncDec = (cmdOp == OP_INC) || (cmdOp == OP_DEC);

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Captured command, repeat counter and swap hold register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cmdOp  <= OP_NOP;
      cmdDst <= '0;
      cmdSrc <= '0;
      cmdImm <= '0;
      cnt    <= '0;
      hold   <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (accept) begin
        cmdOp  <= op_e'(cmd_op);
        cmdDst <= cmd_dst;
        cmdSrc <= cmd_src;
        cmdImm <= cmd_imm;
        cnt    <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
      end else if (state == ST_EXEC && isIncDec) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ST_EXEC && cmdOp == OP_SWAP) hold <= rf_out_a;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid) nextState = ST_EXEC;
      ST_EXEC: begin
        if (isIncDec)               nextState = (cnt <= CNT_W'(1)) ? ST_DONE : ST_EXEC;
        else if (cmdOp == OP_SWAP)  nextState = ST_SWAP2;
        else                        nextState = ST_DONE;
      end
      ST_SWAP2: nextState = ST_DONE;
      ST_DONE:  nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    I         = '0;
    OutASel   = '0;
    OutBSel   = '0;
    FunSel    = FUN_DEC;
    wrEn      = 1'b0;
    wrAddr    = cmdDst;
    if (state == ST_EXEC) begin
      case (cmdOp)
        OP_LOAD:  begin FunSel = FUN_LOAD;  I = cmdImm; wrEn = 1'b1; end
        OP_CLEAR: begin FunSel = FUN_CLEAR; wrEn = 1'b1; end
        OP_INC:   begin FunSel = FUN_INC;   wrEn = 1'b1; end
        OP_DEC:   begin FunSel = FUN_DEC;   wrEn = 1'b1; end
        OP_MOVE: begin
          OutASel = cmdSrc;
          I       = rf_out_a;
          FunSel  = FUN_LOAD;
          wrEn    = 1'b1;
        end
        // First half of swap: dst takes src while dst's old value goes to hold
        OP_SWAP: begin
          OutASel = cmdDst;
          OutBSel = cmdSrc;
          I       = rf_out_b;
          FunSel  = FUN_LOAD;
          wrEn    = 1'b1;
        end
        default: ;
      endcase
    end else if (state == ST_SWAP2) begin
      I      = hold;
      FunSel = FUN_LOAD;
      wrEn   = 1'b1;
      wrAddr = cmdSrc;
    end
  end

  rf_addr_decoder uDecoder (
    .addr   (wrAddr),
    .en     (wrEn),
    .regSel (RegSel),
    .scrSel (ScrSel)
  );

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer driving a small behavioural RegisterFile model.
module tb_rf_op_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_op, cmd_dst, cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] rfOutA, rfOutB, I;
  logic [2:0]        OutASel, OutBSel, FunSel;
  logic [3:0]        RegSel, ScrSel;
  logic              busy, done;

  always #5 Clock = ~Clock;

  rf_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_imm   (cmd_imm),
    .cmd_count (cmd_count),
    .rf_out_a  (rfOutA),
    .rf_out_b  (rfOutB),
    .I         (I),
    .OutASel   (OutASel),
    .OutBSel   (OutBSel),
    .FunSel    (FunSel),
    .RegSel    (RegSel),
    .ScrSel    (ScrSel),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural RegisterFile: index 0 = R1/S1, 3 = R4/S4
  logic [31:0] rfR [4];
  logic [31:0] rfS [4];

  assign rfOutA = OutASel[2] ? rfS[OutASel[1:0]] : rfR[OutASel[1:0]];
  assign rfOutB = OutBSel[2] ? rfS[OutBSel[1:0]] : rfR[OutBSel[1:0]];

  function automatic logic [31:0] rfFun(input logic [2:0] fs, input logic [31:0] v,
                                        input logic [31:0] d);
    case (fs)
      3'd0:    return v - 32'd1;
      3'd1:    return v + 32'd1;
      3'd2:    return d;
      3'd3:    return 32'd0;
      default: return v;
    endcase
  endfunction

  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (RegSel[3-i]) rfR[i] <= rfFun(FunSel, rfR[i], I);
      if (ScrSel[3-i]) rfS[i] <= rfFun(FunSel, rfS[i], I);
    end
  end

  function automatic logic [31:0] rfRd(input logic [2:0] a);
    return a[2] ? rfS[a[1:0]] : rfR[a[1:0]];
  endfunction

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  int         lat, wr, multi;
  logic [7:0] selSeen;
  logic [2:0] funSeen;

  // Issue one command, then watch until done, recording latency and write cycles
  task automatic runCmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [31:0] imm, input logic [3:0] count);
    @(negedge Clock);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_count = count;
    cmd_valid = 1'b1;
    @(posedge Clock);
    lat = 0; wr = 0; multi = 0; selSeen = '0; funSeen = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      cmd_valid = 1'b0;
      lat++;
      if ({RegSel, ScrSel} != 8'h00) begin
        wr++;
        selSeen |= {RegSel, ScrSel};
        funSeen = FunSel;
        if ($countones({RegSel, ScrSel}) != 1) multi++;
      end
      if (done) break;
    end
    checkVal("done seen", 32'(done), 32'd1);
  endtask

  int readyAt, doneSeen;

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0;
    cmd_imm = '0; cmd_count = '0;
    repeat (3) @(negedge Clock);
    checkVal("rst ready", 32'(cmd_ready), 32'd1);
    checkVal("rst busy", 32'(busy), 32'd0);
    checkVal("rst done", 32'(done), 32'd0);
    checkVal("rst sel", 32'({RegSel, ScrSel}), 32'd0);
    checkVal("rst fun/outsel", 32'({FunSel, OutASel, OutBSel}), 32'd0);
    checkVal("rst I", I, 32'd0);
    Reset = 1'b0;

    // Preload all eight registers with distinct values
    for (int a = 0; a < 8; a++) runCmd(3'd1, 3'(a), 3'd0, 32'h1111_1111 * (a + 1), 4'd0);
    for (int a = 0; a < 8; a++) checkVal("preload", rfRd(3'(a)), 32'h1111_1111 * (a + 1));

    runCmd(3'd1, 3'd5, 3'd0, 32'h3456_7890, 4'd0);
    checkVal("load lat", lat, 3);
    checkVal("load wr", wr, 1);
    checkVal("load sel", 32'(selSeen), 32'h04);
    checkVal("load fun", 32'(funSeen), 32'd2);
    checkVal("load S2", rfRd(3'd5), 32'h3456_7890);

    runCmd(3'd1, 3'd0, 3'd0, 32'h0000_0010, 4'd0);
    runCmd(3'd3, 3'd0, 3'd0, 32'd0, 4'd3);
    checkVal("inc3 lat", lat, 5);
    checkVal("inc3 wr", wr, 3);
    checkVal("inc3 sel", 32'(selSeen), 32'h80);
    checkVal("inc3 fun", 32'(funSeen), 32'd1);
    checkVal("inc3 R1", rfRd(3'd0), 32'h0000_0013);
    runCmd(3'd3, 3'd0, 3'd0, 32'd0, 4'd0);
    checkVal("inc0 lat", lat, 3);
    checkVal("inc0 wr", wr, 1);
    checkVal("inc0 R1", rfRd(3'd0), 32'h0000_0014);

    runCmd(3'd1, 3'd4, 3'd0, 32'd1, 4'd0);
    runCmd(3'd4, 3'd4, 3'd0, 32'd0, 4'd2);
    checkVal("dec lat", lat, 4);
    checkVal("dec fun", 32'(funSeen), 32'd0);
    checkVal("dec sel", 32'(selSeen), 32'h08);
    checkVal("dec wrap S1", rfRd(3'd4), 32'hFFFF_FFFF);

    runCmd(3'd1, 3'd1, 3'd0, 32'h1234_5678, 4'd0);
    runCmd(3'd1, 3'd2, 3'd0, 32'h5678_1234, 4'd0);
    runCmd(3'd6, 3'd1, 3'd2, 32'd0, 4'd0);
    checkVal("swap lat", lat, 4);
    checkVal("swap wr", wr, 2);
    checkVal("swap sel", 32'(selSeen), 32'h60);
    checkVal("swap onehot", multi, 0);
    checkVal("swap R2", rfRd(3'd1), 32'h5678_1234);
    checkVal("swap R3", rfRd(3'd2), 32'h1234_5678);
    checkVal("swap R1 kept", rfRd(3'd0), 32'h0000_0014);
    checkVal("swap R4 kept", rfRd(3'd3), 32'h4444_4444);

    runCmd(3'd1, 3'd7, 3'd0, 32'hDEAD_BEEF, 4'd0);
    runCmd(3'd5, 3'd0, 3'd7, 32'd0, 4'd0);
    checkVal("move lat", lat, 3);
    checkVal("move R1", rfRd(3'd0), 32'hDEAD_BEEF);
    checkVal("move S4 kept", rfRd(3'd7), 32'hDEAD_BEEF);
    runCmd(3'd5, 3'd3, 3'd3, 32'd0, 4'd0);
    checkVal("self move wr", wr, 1);
    checkVal("self move R4", rfRd(3'd3), 32'h4444_4444);

    runCmd(3'd2, 3'd6, 3'd0, 32'd0, 4'd0);
    checkVal("clear fun", 32'(funSeen), 32'd3);
    checkVal("clear S3", rfRd(3'd6), 32'd0);
    runCmd(3'd7, 3'd1, 3'd0, 32'hFFFF_FFFF, 4'd0);
    checkVal("op7 lat", lat, 3);
    checkVal("op7 wr", wr, 0);
    runCmd(3'd0, 3'd2, 3'd0, 32'hFFFF_FFFF, 4'd0);
    checkVal("nop wr", wr, 0);

    // Second command held valid throughout a SWAP
    @(negedge Clock);
    cmd_op = 3'd6; cmd_dst = 3'd2; cmd_src = 3'd1; cmd_valid = 1'b1;
    @(posedge Clock);
    readyAt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      cmd_op = 3'd1; cmd_dst = 3'd3; cmd_imm = 32'hCAFE_0001;
      readyAt = n + 1;
      if (cmd_ready) break;
    end
    checkVal("held ready cycle", readyAt, 4);
    checkVal("held done with ready", 32'(done), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid = 1'b0;
    checkVal("held accepted", 32'(busy), 32'd1);
    for (int n = 0; n < 20; n++) begin
      if (done) break;
      @(negedge Clock);
    end
    checkVal("held 2nd done", 32'(done), 32'd1);
    checkVal("held R2", rfRd(3'd1), 32'h1234_5678);
    checkVal("held R3", rfRd(3'd2), 32'h5678_1234);
    checkVal("held R4", rfRd(3'd3), 32'hCAFE_0001);

    // Reset in the middle of an INC count=8
    runCmd(3'd1, 3'd0, 3'd0, 32'd100, 4'd0);
    @(negedge Clock);
    cmd_op = 3'd3; cmd_dst = 3'd0; cmd_count = 4'd8; cmd_valid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid = 1'b0;
    @(negedge Clock);
    checkVal("abort 2nd write", 32'(RegSel), 32'h8);
    Reset = 1'b1;
    @(negedge Clock);
    checkVal("abort busy", 32'(busy), 32'd0);
    checkVal("abort sel", 32'({RegSel, ScrSel}), 32'd0);
    checkVal("abort fun", 32'(FunSel), 32'd0);
    Reset = 1'b0;
    doneSeen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clock);
      if (done) doneSeen++;
    end
    checkVal("abort no done", doneSeen, 0);
    checkVal("abort ready", 32'(cmd_ready), 32'd1);
    checkVal("abort R1", rfRd(3'd0), 32'd102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
